flash_bridge_ctrl: RTL and testbench
====================================

Name: flash_bridge_ctrl

Overview:
- Parametrised successor to the single-purpose flash path in the camera controller: converts host-side byte-stream requests into command sequences for the SPI flash master (`spi_memory_master` handshake).
- Supports READ or FAST_READ, PAGE_PROGRAM with automatic WREN, SECTOR_ERASE and READ_STATUS.
- After PROGRAM and ERASE it polls the flash WIP bit, bounded by a timeout.
- Sits between the memory-SPI slave glue and the flash master; reports sticky error bits to the control register file.

Parameters:
- ADDR_W, 24, flash address width in bits.
- FAST_READ, 0, 1 selects opcode 0x0B with DUMMY_CYC dummy cycles; 0 selects 0x03 with 0 dummy cycles.
- DUMMY_CYC, 8, dummy cycles for FAST_READ (4-bit field).
- PAGE_SIZE, 256, program page size in bytes (power of two).
- POLL_MAX, 65535, maximum RDSR polls before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  one-cycle request strobe
- req_op  in  2  0=READ, 1=PROGRAM, 2=ERASE, 3=READ_STATUS
- req_addr  in  ADDR_W  start address
- req_ready  out  1  bridge idle and flash master not busy
- wr_data  in  8  program byte
- wr_valid  in  1  program byte strobe
- rd_req  in  1  host requests next read byte
- rd_data  out  8  last byte read
- rd_valid  out  1  one-cycle strobe, rd_data updated
- end_op  in  1  host released chip select (pulse)
- busy  out  1  state != IDLE
- err  out  4  sticky: [0] byte overrun, [1] poll timeout, [2] page overflow, [3] request rejected
- err_clr  in  1  clears err
- m_opcode  out  8  flash master opcode
- m_addr  out  ADDR_W  flash master address
- m_addr_flag  out  1  send address phase
- m_dummy  out  4  dummy cycles
- m_write  out  8  byte to transmit
- m_read  in  8  received byte
- m_oa_trigger  out  1  opcode/address trigger (level)
- m_oa_completed  in  1  opcode/address phase done
- m_data_trigger  out  1  data byte trigger (level)
- m_data_completed  in  1  data byte done
- m_finalize  out  1  terminate transaction
- m_busy  in  1  flash master interface busy

Behaviour:
- Reset:
  - All outputs 0, except m_write=8'hFF.
  - State IDLE. Edge-detect registers cleared. Takes effect immediately, including mid-transaction.
- Edge detection: m_oa_completed and m_data_completed are consumed on rising edge only (registered previous value).
- req_ready = (state==IDLE) && !m_busy.
  - req_valid && !req_ready sets err[3]; the request is dropped.
- Acceptance: on req_valid && req_ready, the next cycle drives opcode/addr registers and enters the first state for the op:
  - READ: opcode 0x03 or 0x0B, addr_flag=1, dummy per FAST_READ; go to CMD.
  - PROGRAM: first WREN (0x06, addr_flag=0); go to WREN; then 0x02; go to CMD.
  - ERASE: WREN, then 0x20 with addr_flag=1; go to CMD.
  - READ_STATUS: 0x05, addr_flag=0; go to CMD.
- States:
  - IDLE
  - WREN: oa_trigger=1 until completed edge; then finalize=1 and go to WREN_FIN.
  - WREN_FIN: when !m_busy, finalize=0 and load the real command; go to CMD.
  - CMD: oa_trigger=1; on completed edge go to DATA. For ERASE, go straight to FINAL.
  - DATA: byte loop.
  - FINAL: finalize=1, triggers 0, hold until !m_busy.
    - PROGRAM/ERASE then go to POLL_CMD.
    - All other ops go to IDLE.
  - POLL_CMD, POLL_DATA, POLL_FIN: RDSR loop.
- DATA for READ / READ_STATUS:
  - rd_req sets data_trigger=1.
  - On completed edge: rd_data<=m_read, rd_valid=1 for one cycle, data_trigger=0.
- DATA for PROGRAM:
  - wr_valid latches m_write<=wr_data and sets data_trigger=1; a byte counter increments.
  - wr_valid or rd_req while data_trigger=1 or m_busy-with-byte-in-flight: set err[0], ignore the byte.
  - Byte that would cross a PAGE_SIZE boundary (addr offset + count == PAGE_SIZE): set err[2], do not send it.
- end_op in DATA: if a byte is in flight, finish it first (wait for the completed edge), then go to FINAL. end_op in any other non-IDLE state is latched and honoured at DATA entry.
- Poll loop:
  - Issue 0x05 and one data byte.
  - If m_read[0]==0, go to IDLE.
  - Else finalize, wait !m_busy, increment poll_cnt and repeat.
  - poll_cnt == POLL_MAX: set err[1], finalize, go to IDLE.
- err_clr has priority over a same-cycle set: the clear wins and the set is lost.
- busy is high from the acceptance cycle until IDLE is re-entered.

Decomposition:
- Shared package flash_pkg:
  - opcodes: OP_READ 0x03, OP_FREAD 0x0B, OP_PP 0x02, OP_WREN 0x06, OP_SE 0x20, OP_RDSR 0x05
  - req_op encodings
  - state enum
  - err bit indices
- One natural sub-module: flash_edge_det (registered rising-edge detector, instantiated twice).

Test Plan:
- READ at 0x000100, FAST_READ=0, two rd_req, model returns 0x5A, 0xC3 -> m_opcode=0x03, m_addr=0x000100, rd_valid twice with 0x5A then 0xC3; end_op -> m_finalize, then req_ready=1.
- PROGRAM at 0x0000FE with bytes 0x11, 0x22, 0x33 -> WREN 0x06 then 0x02; 0x11 and 0x22 sent; 0x33 sets err[2]. RDSR polls return 0x01, 0x01, 0x00 -> exactly 3 RDSR transactions, then IDLE.
- ERASE at 0x001000, model WIP stuck at 1, POLL_MAX=4 -> 0x06, 0x20, four RDSR polls, err[1]=1, busy falls.
- Second wr_valid before the first m_data_completed edge -> err[0]=1, m_write holds the first byte; err_clr -> err=0.
- req_valid while busy -> err[3]=1, no change on m_opcode. Assert rst mid-DATA -> next edge all triggers 0, busy=0, state IDLE.

Source files
------------

// File: rtl/flash_pkg.sv
// flash_pkg: shared definitions for the flash bridge.
//   - SPI flash opcodes used by the bridge
//   - host request encodings (req_op)
//   - bridge FSM state type
//   - bit positions within the sticky err vector
package flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_SE    = 8'h20;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [1:0] {
        ReqRead    = 2'd0,
        ReqProgram = 2'd1,
        ReqErase   = 2'd2,
        ReqStatus  = 2'd3
    } req_op_e;

    typedef enum logic [3:0] {
        StIdle,
        StWren,
        StWrenFin,
        StCmd,
        StData,
        StFinal,
        StPollCmd,
        StPollData,
        StPollFin
    } state_e;

    localparam int unsigned ERR_OVERRUN = 0;
    localparam int unsigned ERR_TIMEOUT = 1;
    localparam int unsigned ERR_PAGE    = 2;
    localparam int unsigned ERR_REJECT  = 3;

endpackage

// File: rtl/flash_bridge_ctrl_if.sv
// flash_bridge_ctrl_if: handshake bundle between the bridge and the SPI flash master.
//   master modport: bridge side (drives opcode/address/triggers/finalize, sees completions)
//   slave modport : flash master side (drives m_read, completions and m_busy)
interface flash_bridge_ctrl_if #(
    parameter int unsigned ADDR_W = 24
);
    logic [7:0]        m_opcode;
    logic [ADDR_W-1:0] m_addr;
    logic              m_addr_flag;
    logic [3:0]        m_dummy;
    logic [7:0]        m_write;
    logic [7:0]        m_read;
    logic              m_oa_trigger;
    logic              m_oa_completed;
    logic              m_data_trigger;
    logic              m_data_completed;
    logic              m_finalize;
    logic              m_busy;

    modport master (
        output m_opcode, m_addr, m_addr_flag, m_dummy, m_write,
        output m_oa_trigger, m_data_trigger, m_finalize,
        input  m_read, m_oa_completed, m_data_completed, m_busy
    );

    modport slave (
        input  m_opcode, m_addr, m_addr_flag, m_dummy, m_write,
        input  m_oa_trigger, m_data_trigger, m_finalize,
        output m_read, m_oa_completed, m_data_completed, m_busy
    );
endinterface

// File: rtl/flash_edge_det.sv
// flash_edge_det: rising-edge detector against a registered copy of the input.
//   clk, rst : clock, asynchronous active-high reset
//   d        : level input (completion flag from the flash master)
//   rise     : high in the cycle where d is 1 and was 0 on the previous edge
module flash_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/flash_bridge_ctrl.sv
// flash_bridge_ctrl: turns host byte-stream requests into SPI flash command sequences.
//   Host side : req_valid/req_op/req_addr/req_ready, wr_data/wr_valid, rd_req/rd_data/rd_valid,
//               end_op, busy, sticky err[3:0] with err_clr.
//   Flash side: interface m (master modport) towards the SPI flash master.
//   PROGRAM and ERASE are preceded by WREN and followed by an RDSR poll on the WIP bit.
module flash_bridge_ctrl
    import flash_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter bit          FAST_READ = 1'b0,
    parameter int unsigned DUMMY_CYC = 8,
    parameter int unsigned PAGE_SIZE = 256,
    parameter int unsigned POLL_MAX  = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    input  logic [7:0]          wr_data,
    input  logic                wr_valid,
    input  logic                rd_req,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    input  logic                end_op,
    output logic                busy,
    output logic [3:0]          err,
    input  logic                err_clr,
    flash_bridge_ctrl_if.master m
);
    localparam int unsigned PW = $clog2(PAGE_SIZE) + 1;
    localparam int unsigned CW = $clog2(POLL_MAX + 1);
    localparam logic [7:0] RD_OPCODE = FAST_READ ? OP_FREAD : OP_READ;
    localparam logic [3:0] RD_DUMMY  = FAST_READ ? 4'(DUMMY_CYC) : 4'd0;

    state_e            state_q;
    req_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        opcode_q, write_q, rd_data_q;
    logic              addr_flag_q, oa_trig_q, data_trig_q, fin_q, rd_valid_q;
    logic [3:0]        dummy_q, err_q, err_set;
    logic [PW-1:0]     cnt_q;
    logic [CW-1:0]     poll_cnt_q;
    logic              poll_done_q, end_pend_q;
    logic              oa_rise, data_rise;
    logic              is_prog, is_read, in_data, page_full, end_now, byte_ok, poll_last;

    flash_edge_det u_oa_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (m.m_oa_completed),
        .rise (oa_rise)
    );

    flash_edge_det u_data_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (m.m_data_completed),
        .rise (data_rise)
    );

    assign req_ready = !rst && (state_q == StIdle) && !m.m_busy;
    assign busy      = (state_q != StIdle);

    always_comb begin
        is_prog   = (op_q == ReqProgram);
        is_read   = (op_q == ReqRead) || (op_q == ReqStatus);
        in_data   = (state_q == StData);
        // Next byte would land on the first byte of the following page.
        page_full = (({1'b0, addr_q[PW-2:0]} + cnt_q) == PW'(PAGE_SIZE));
        // A pending end waits for the in-flight byte's completion edge.
        end_now   = in_data && (end_op || end_pend_q) && (!data_trig_q || data_rise);
        byte_ok   = in_data && !end_op && !end_pend_q && !data_trig_q;
        poll_last = (poll_cnt_q == CW'(POLL_MAX - 1));

        err_set              = '0;
        err_set[ERR_REJECT]  = req_valid && !req_ready;
        err_set[ERR_OVERRUN] = in_data && (wr_valid || rd_req) && data_trig_q;
        err_set[ERR_PAGE]    = byte_ok && is_prog && wr_valid && page_full;
        err_set[ERR_TIMEOUT] = (state_q == StPollData) && data_rise && m.m_read[0] && poll_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= ReqRead;
            addr_q      <= '0;
            opcode_q    <= 8'h00;
            addr_flag_q <= 1'b0;
            dummy_q     <= 4'd0;
            write_q     <= 8'hFF;
            oa_trig_q   <= 1'b0;
            data_trig_q <= 1'b0;
            fin_q       <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            cnt_q       <= '0;
            poll_cnt_q  <= '0;
            poll_done_q <= 1'b0;
            end_pend_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (end_op && state_q != StIdle && state_q != StData) begin
                end_pend_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        op_q       <= req_op_e'(req_op);
                        addr_q     <= req_addr;
                        cnt_q      <= '0;
                        poll_cnt_q <= '0;
                        end_pend_q <= 1'b0;
                        oa_trig_q  <= 1'b1;
                        dummy_q    <= 4'd0;
                        case (req_op_e'(req_op))
                            ReqRead: begin
                                opcode_q    <= RD_OPCODE;
                                addr_flag_q <= 1'b1;
                                dummy_q     <= RD_DUMMY;
                                state_q     <= StCmd;
                            end
                            ReqStatus: begin
                                opcode_q    <= OP_RDSR;
                                addr_flag_q <= 1'b0;
                                state_q     <= StCmd;
                            end
                            default: begin
                                opcode_q    <= OP_WREN;
                                addr_flag_q <= 1'b0;
                                state_q     <= StWren;
                            end
                        endcase
                    end
                end
                StWren: begin
                    if (oa_rise) begin
                        oa_trig_q <= 1'b0;
                        fin_q     <= 1'b1;
                        state_q   <= StWrenFin;
                    end
                end
                StWrenFin: begin
                    if (!m.m_busy) begin
                        fin_q       <= 1'b0;
                        opcode_q    <= is_prog ? OP_PP : OP_SE;
                        addr_flag_q <= 1'b1;
                        oa_trig_q   <= 1'b1;
                        state_q     <= StCmd;
                    end
                end
                StCmd: begin
                    if (oa_rise) begin
                        oa_trig_q <= 1'b0;
                        if (op_q == ReqErase) begin
                            fin_q   <= 1'b1;
                            state_q <= StFinal;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (data_rise) begin
                        data_trig_q <= 1'b0;
                        if (is_read) begin
                            rd_data_q  <= m.m_read;
                            rd_valid_q <= 1'b1;
                        end
                    end
                    if (end_now) begin
                        fin_q      <= 1'b1;
                        end_pend_q <= 1'b0;
                        state_q    <= StFinal;
                    end else if (end_op) begin
                        end_pend_q <= 1'b1;
                    end else if (byte_ok) begin
                        if (is_read && rd_req) begin
                            data_trig_q <= 1'b1;
                        end else if (is_prog && wr_valid && !page_full) begin
                            write_q     <= wr_data;
                            data_trig_q <= 1'b1;
                            cnt_q       <= cnt_q + 1'b1;
                        end
                    end
                end
                StFinal: begin
                    if (!m.m_busy) begin
                        fin_q <= 1'b0;
                        if (op_q == ReqProgram || op_q == ReqErase) begin
                            opcode_q    <= OP_RDSR;
                            addr_flag_q <= 1'b0;
                            dummy_q     <= 4'd0;
                            oa_trig_q   <= 1'b1;
                            state_q     <= StPollCmd;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StPollCmd: begin
                    if (oa_rise) begin
                        oa_trig_q   <= 1'b0;
                        data_trig_q <= 1'b1;
                        state_q     <= StPollData;
                    end
                end
                StPollData: begin
                    if (data_rise) begin
                        data_trig_q <= 1'b0;
                        fin_q       <= 1'b1;
                        poll_done_q <= !m.m_read[0] || poll_last;
                        state_q     <= StPollFin;
                    end
                end
                StPollFin: begin
                    if (!m.m_busy) begin
                        fin_q <= 1'b0;
                        if (poll_done_q) begin
                            state_q <= StIdle;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 1'b1;
                            oa_trig_q  <= 1'b1;
                            state_q    <= StPollCmd;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_data          = rd_data_q;
    assign rd_valid         = rd_valid_q;
    assign err              = err_q;
    assign m.m_opcode       = opcode_q;
    assign m.m_addr         = addr_q;
    assign m.m_addr_flag    = addr_flag_q;
    assign m.m_dummy        = dummy_q;
    assign m.m_write        = write_q;
    assign m.m_oa_trigger   = oa_trig_q;
    assign m.m_data_trigger = data_trig_q;
    assign m.m_finalize     = fin_q;
endmodule

// File: tb/tb_flash_bridge_ctrl.sv
// Directed bench for flash_bridge_ctrl with a behavioural SPI flash master model.
module tb_flash_bridge_ctrl;
    logic        clk, rst;
    logic        req_valid, req_ready, wr_valid, rd_req, rd_valid, end_op, busy, err_clr;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [7:0]  wr_data, rd_data;
    logic [3:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rd_q[$];
    logic [7:0] op_log[$];
    logic [7:0] wr_log[$];

    flash_bridge_ctrl_if #(.ADDR_W(24)) mif ();

    flash_bridge_ctrl #(
        .ADDR_W    (24),
        .FAST_READ (1'b0),
        .DUMMY_CYC (8),
        .PAGE_SIZE (256),
        .POLL_MAX  (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .end_op    (end_op),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .m         (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash master model: completion levels rise 3 cycles after a trigger and fall when it drops.
    logic oa_prev, dt_prev;
    int   oa_cnt, dt_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mif.m_oa_completed   <= 1'b0;
            mif.m_data_completed <= 1'b0;
            mif.m_busy           <= 1'b0;
            mif.m_read           <= 8'h00;
            oa_prev <= 1'b0;
            dt_prev <= 1'b0;
            oa_cnt  <= 0;
            dt_cnt  <= 0;
        end else begin
            oa_prev <= mif.m_oa_trigger;
            dt_prev <= mif.m_data_trigger;
            if (mif.m_oa_trigger && !oa_prev) op_log.push_back(mif.m_opcode);
            if (mif.m_data_trigger && !dt_prev && mif.m_opcode == 8'h02)
                wr_log.push_back(mif.m_write);
            if (!mif.m_oa_trigger) begin
                mif.m_oa_completed <= 1'b0;
                oa_cnt <= 0;
            end else if (!mif.m_oa_completed) begin
                if (oa_cnt == 2) mif.m_oa_completed <= 1'b1;
                else oa_cnt <= oa_cnt + 1;
            end
            if (!mif.m_data_trigger) begin
                mif.m_data_completed <= 1'b0;
                dt_cnt <= 0;
            end else if (!mif.m_data_completed) begin
                if (dt_cnt == 2) begin
                    mif.m_data_completed <= 1'b1;
                    if (mif.m_opcode != 8'h02) begin
                        if (rd_q.size() > 0) mif.m_read <= rd_q.pop_front();
                        else mif.m_read <= 8'h00;
                    end
                end else begin
                    dt_cnt <= dt_cnt + 1;
                end
            end
            if (mif.m_finalize) mif.m_busy <= 1'b0;
            else if (mif.m_oa_trigger) mif.m_busy <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [23:0] a);
        req_valid = 1'b1; req_op = op; req_addr = a;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] b);
        wr_data = b; wr_valid = 1'b1;
        tick;
        wr_valid = 1'b0;
    endtask

    task automatic do_rd;
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
    endtask

    task automatic do_end;
        end_op = 1'b1;
        tick;
        end_op = 1'b0;
    endtask

    task automatic do_clr;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
    endtask

    task automatic wait_cmd_done(input logic [7:0] opc, input string tag);
        for (int i = 0; i < 100; i++) begin
            if (mif.m_opcode == opc && !mif.m_oa_trigger) break;
            tick;
        end
        check({tag, "_opcode"}, 32'(mif.m_opcode), 32'(opc));
        check({tag, "_oa_trig"}, 32'(mif.m_oa_trigger), 32'd0);
    endtask

    task automatic wait_data_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!mif.m_data_trigger) break;
            tick;
        end
        check(tag, 32'(mif.m_data_trigger), 32'd0);
    endtask

    task automatic wait_rdv(input logic [7:0] exp, input string tag);
        for (int i = 0; i < 100; i++) begin
            if (rd_valid) break;
            tick;
        end
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            tick;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    function automatic int count_op(input logic [7:0] o);
        int n = 0;
        foreach (op_log[i]) if (op_log[i] == o) n++;
        return n;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; wr_data = 8'h00;
        wr_valid = 1'b0; rd_req = 1'b0; end_op = 1'b0; err_clr = 1'b0;
        repeat (3) tick;

        // Reset values
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_m_write", 32'(mif.m_write), 32'hFF);
        check("rst_triggers", {30'd0, mif.m_oa_trigger, mif.m_data_trigger}, 32'd0);
        check("rst_finalize", 32'(mif.m_finalize), 32'd0);
        rst = 1'b0;
        tick;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // READ at 0x000100, two bytes
        rd_q = '{8'h5A, 8'hC3};
        op_log.delete();
        do_req(2'd0, 24'h000100);
        check("rd_opcode", 32'(mif.m_opcode), 32'h03);
        check("rd_addr", 32'(mif.m_addr), 32'h000100);
        check("rd_addr_flag", 32'(mif.m_addr_flag), 32'd1);
        check("rd_dummy", 32'(mif.m_dummy), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        wait_cmd_done(8'h03, "rd_cmd");
        do_rd;
        wait_rdv(8'h5A, "rd_b0");
        do_rd;
        wait_rdv(8'hC3, "rd_b1");
        do_end;
        check("rd_finalize", 32'(mif.m_finalize), 32'd1);
        wait_idle("rd_idle");
        tick;
        check("rd_ready", 32'(req_ready), 32'd1);
        check("rd_ops", 32'(op_log.size()), 32'd1);

        // PROGRAM at 0x0000FE: third byte crosses the page
        rd_q = '{8'h01, 8'h01, 8'h00};
        op_log.delete();
        wr_log.delete();
        do_req(2'd1, 24'h0000FE);
        check("pp_wren_opcode", 32'(mif.m_opcode), 32'h06);
        check("pp_wren_flag", 32'(mif.m_addr_flag), 32'd0);
        wait_cmd_done(8'h02, "pp_cmd");
        check("pp_addr", 32'(mif.m_addr), 32'h0000FE);
        do_wr(8'h11);
        wait_data_idle("pp_b0_done");
        do_wr(8'h22);
        wait_data_idle("pp_b1_done");
        do_wr(8'h33);
        check("pp_page_err", 32'(err), 32'h4);
        check("pp_b2_not_sent", 32'(mif.m_data_trigger), 32'd0);
        do_end;
        wait_idle("pp_idle");
        check("pp_op0", 32'(op_log[0]), 32'h06);
        check("pp_op1", 32'(op_log[1]), 32'h02);
        check("pp_rdsr_count", 32'(count_op(8'h05)), 32'd3);
        check("pp_wr_count", 32'(wr_log.size()), 32'd2);
        check("pp_wr0", 32'(wr_log[0]), 32'h11);
        check("pp_wr1", 32'(wr_log[1]), 32'h22);
        check("pp_err_kept", 32'(err), 32'h4);
        do_clr;
        check("pp_err_clr", 32'(err), 32'd0);

        // ERASE at 0x001000 with WIP stuck: poll timeout after 4 polls
        rd_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        op_log.delete();
        do_req(2'd2, 24'h001000);
        check("se_addr", 32'(mif.m_addr), 32'h001000);
        wait_idle("se_idle");
        check("se_op0", 32'(op_log[0]), 32'h06);
        check("se_op1", 32'(op_log[1]), 32'h20);
        check("se_rdsr_count", 32'(count_op(8'h05)), 32'd4);
        check("se_timeout_err", 32'(err), 32'h2);
        rd_q.delete();
        do_clr;

        // Byte overrun during PROGRAM
        rd_q = '{8'h00};
        wr_log.delete();
        do_req(2'd1, 24'h000010);
        wait_cmd_done(8'h02, "ov_cmd");
        do_wr(8'hAA);
        do_wr(8'hBB);
        check("ov_err", 32'(err), 32'h1);
        check("ov_m_write", 32'(mif.m_write), 32'hAA);
        wait_data_idle("ov_done");
        do_end;
        wait_idle("ov_idle");
        check("ov_wr_log", 32'(wr_log.size()), 32'd1);
        do_clr;
        check("ov_err_clr", 32'(err), 32'd0);

        // Rejected request while busy, clear-vs-set priority, reset mid-DATA
        rd_q = '{8'h77};
        do_req(2'd0, 24'h000200);
        do_req(2'd3, 24'h000000);
        check("rej_err", 32'(err), 32'h8);
        check("rej_opcode", 32'(mif.m_opcode), 32'h03);
        err_clr = 1'b1;
        do_req(2'd3, 24'h000000);
        err_clr = 1'b0;
        check("clr_wins", 32'(err), 32'd0);
        wait_cmd_done(8'h03, "rst_cmd");
        do_rd;
        check("dtrig_before_rst", 32'(mif.m_data_trigger), 32'd1);
        rst = 1'b1;
        tick;
        check("midrst_triggers", {30'd0, mif.m_oa_trigger, mif.m_data_trigger}, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_finalize", 32'(mif.m_finalize), 32'd0);
        check("midrst_m_write", 32'(mif.m_write), 32'hFF);
        rst = 1'b0;
        rd_q.delete();
        tick;
        check("midrst_ready", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
